chasy_time_counter: RTL and testbench

Free-running timekeeping core for the clock. It divides the system clock down to a 1 Hz tick and keeps hours, minutes and seconds as a binary counter chain. It loads a new time from the setup stage when `setup_imp` pulses, and drives `data_ch` to the setup and display stages. It sits directly downstream of the setup block and consumes `setup_data`/`setup_imp`.

---
 rtl/chasy_pkg.sv | 36 +++
 rtl/chasy_tick_gen.sv | 38 +++
 rtl/chasy_time_counter.sv | 100 ++++++++++
 tb/tb_chasy_time_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/chasy_pkg.sv
// Shared types, field limits and load-check helpers for the chasy timekeeping core.
package chasy_pkg;

  localparam int          FIELD_W      = 8;
  localparam logic [7:0]  SEC_MAX      = 8'd59;
  localparam logic [7:0]  MIN_MAX      = 8'd59;
  localparam logic [7:0]  HOUR_MAX     = 8'd23;
  localparam logic [1:0]  SETUP_REZHIM = 2'd3;

  typedef struct packed {
    logic [FIELD_W-1:0] hh;
    logic [FIELD_W-1:0] mm;
    logic [FIELD_W-1:0] ss;
  } chasy_time_t;

  function automatic logic [FIELD_W-1:0] check_field(input logic [FIELD_W-1:0] value,
                                                     input logic [FIELD_W-1:0] max_value);
    logic [FIELD_W-1:0] result;
    if (value > max_value) begin
      result = 8'd0;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // Out-of-range fields are zeroed independently so a bad hour never disturbs minutes/seconds.
  function automatic chasy_time_t check_time(input logic [3*FIELD_W-1:0] raw);
    chasy_time_t result;
    result.hh = check_field(raw[23:16], HOUR_MAX);
    result.mm = check_field(raw[15:8], MIN_MAX);
    result.ss = check_field(raw[7:0], SEC_MAX);
    return result;
  endfunction

endpackage

// File: rtl/chasy_tick_gen.sv
// Prescaler: one tick per CLK_DIV clocks; hold freezes it at zero, clr restarts the second.
module chasy_tick_gen #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count_r;
  logic             tick_r;

  // Prescaler count and registered terminal-count tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
      tick_r  <= 1'b0;
    end else if (hold || clr) begin
      count_r <= {CNT_W{1'b0}};
      tick_r  <= 1'b0;
    end else if (count_r == CNT_LAST) begin
      count_r <= {CNT_W{1'b0}};
      tick_r  <= 1'b1;
    end else begin
      count_r <= count_r + CNT_W'(1);
      tick_r  <= 1'b0;
    end
  end

  // Masking with hold also kills a tick already in flight when setup mode is entered.
  assign tick = tick_r & ~hold;

endmodule

// File: rtl/chasy_time_counter.sv
// Timekeeping core: hh:mm:ss binary counter chain with edge-triggered, range-checked time load.
module chasy_time_counter
  import chasy_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  rezhim,
  input  logic [23:0] setup_data,
  input  logic        setup_imp,
  output logic [23:0] data_ch,
  output logic        sec_pulse,
  output logic        day_wrap
);

  chasy_time_t time_r;
  chasy_time_t time_inc_s;
  chasy_time_t time_next_s;
  logic        setup_imp_d_r;
  logic        sec_pulse_r;
  logic        day_wrap_r;
  logic        load_s;
  logic        freeze_s;
  logic        tick_s;
  logic        wrap_s;
  logic        sec_pulse_next_s;
  logic        day_wrap_next_s;

  assign load_s   = setup_imp & ~setup_imp_d_r;
  assign freeze_s = (rezhim == SETUP_REZHIM);

  chasy_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .hold  (freeze_s),
    .clr   (load_s),
    .tick  (tick_s)
  );

  // Seconds -> minutes -> hours carry chain; >= guards against any out-of-range state.
  always_comb begin
    time_inc_s = time_r;
    wrap_s     = 1'b0;
    if (time_r.ss >= SEC_MAX) begin
      time_inc_s.ss = 8'd0;
      if (time_r.mm >= MIN_MAX) begin
        time_inc_s.mm = 8'd0;
        if (time_r.hh >= HOUR_MAX) begin
          time_inc_s.hh = 8'd0;
          wrap_s        = 1'b1;
        end else begin
          time_inc_s.hh = time_r.hh + 8'd1;
        end
      end else begin
        time_inc_s.mm = time_r.mm + 8'd1;
      end
    end else begin
      time_inc_s.ss = time_r.ss + 8'd1;
    end
  end

  // Load beats tick: a tick coinciding with a load edge is dropped along with its pulses.
  always_comb begin
    time_next_s      = time_r;
    sec_pulse_next_s = 1'b0;
    day_wrap_next_s  = 1'b0;
    if (load_s) begin
      time_next_s = check_time(setup_data);
    end else if (tick_s) begin
      time_next_s      = time_inc_s;
      sec_pulse_next_s = 1'b1;
      day_wrap_next_s  = wrap_s;
    end else begin
      time_next_s = time_r;
    end
  end

  // Time, pulse and load edge-detect registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      time_r        <= '{hh: 8'd0, mm: 8'd0, ss: 8'd0};
      sec_pulse_r   <= 1'b0;
      day_wrap_r    <= 1'b0;
      setup_imp_d_r <= 1'b0;
    end else begin
      time_r        <= time_next_s;
      sec_pulse_r   <= sec_pulse_next_s;
      day_wrap_r    <= day_wrap_next_s;
      setup_imp_d_r <= setup_imp;
    end
  end

  assign data_ch   = time_r;
  assign sec_pulse = sec_pulse_r;
  assign day_wrap  = day_wrap_r;

endmodule

// File: tb/tb_chasy_time_counter.sv
// Directed bench for chasy_time_counter (CLK_DIV = 4) with a scoreboard of expected sec_pulse results.
module tb_chasy_time_counter;

  logic        clock;
  logic        reset;
  logic [1:0]  rezhim;
  logic [23:0] setup_data;
  logic        setup_imp;
  logic [23:0] data_ch;
  logic        sec_pulse;
  logic        day_wrap;

  typedef struct {
    logic [23:0] data;
    logic        wrap;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   pulse_cnt = 0;
  int   cyc;
  int   saved_cnt;

  chasy_time_counter #(
    .CLK_DIV (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rezhim     (rezhim),
    .setup_data (setup_data),
    .setup_imp  (setup_imp),
    .data_ch    (data_ch),
    .sec_pulse  (sec_pulse),
    .day_wrap   (day_wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic [23:0] d, input logic w);
    exp_t e;
    e.data = d;
    e.wrap = w;
    sb_q.push_back(e);
  endtask

  // Counts negedges until sec_pulse is seen, bounded by max_c.
  task automatic wait_pulse(input int max_c, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (sec_pulse !== 1'b1 && n < max_c);
    chk("pulse_seen", {31'd0, sec_pulse}, 32'd1);
  endtask

  // Scoreboard: every pulse must have been announced, and must carry the announced time/wrap.
  always @(negedge clock) begin
    if (sec_pulse === 1'b1) begin
      exp_t e;
      pulse_cnt++;
      chk("pulse_expected", {31'd0, (sb_q.size() != 0)}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("pulse_data", {8'd0, data_ch}, {8'd0, e.data});
        chk("pulse_wrap", {31'd0, day_wrap}, {31'd0, e.wrap});
      end
    end
    if (day_wrap === 1'b1) begin
      chk("wrap_needs_pulse", {31'd0, sec_pulse}, 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    rezhim     = 2'd0;
    setup_data = 24'h000000;
    setup_imp  = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_data", {8'd0, data_ch}, 32'd0);
    chk("rst_pulse", {30'd0, sec_pulse, day_wrap}, 32'd0);

    // Free run from reset: prescaler counts 1,2,3 then ticks; pulse on the 5th negedge.
    reset = 1'b1;
    push_exp(24'h000001, 1'b0);
    wait_pulse(10, cyc);
    chk("first_pulse_lat", cyc, 32'd5);

    // Count: 00:00:58 -> :59 -> 00:01:00.
    setup_data = 24'h00003A;
    setup_imp  = 1'b1;
    @(negedge clock);
    chk("load_58", {8'd0, data_ch}, 32'h00003A);
    chk("load_no_pulse", {31'd0, sec_pulse}, 32'd0);
    setup_imp = 1'b0;
    push_exp(24'h00003B, 1'b0);
    push_exp(24'h000100, 1'b0);
    wait_pulse(10, cyc);
    chk("post_load_lat", cyc, 32'd5);
    wait_pulse(10, cyc);
    chk("pulse_period", cyc, 32'd4);

    // Day wrap.
    setup_data = 24'h173B3B;
    setup_imp  = 1'b1;
    @(negedge clock);
    chk("load_235959", {8'd0, data_ch}, 32'h173B3B);
    setup_imp = 1'b0;
    push_exp(24'h000000, 1'b1);
    wait_pulse(10, cyc);
    chk("wrap_lat", cyc, 32'd5);
    chk("wrap_flag", {31'd0, day_wrap}, 32'd1);

    // Field check on load; this negedge also confirms day_wrap lasted one cycle.
    @(negedge clock);
    chk("wrap_one_cycle", {30'd0, sec_pulse, day_wrap}, 32'd0);
    setup_data = 24'h183C3C;
    setup_imp  = 1'b1;
    @(negedge clock);
    chk("load_all_bad", {8'd0, data_ch}, 32'h000000);
    setup_imp = 1'b0;
    @(negedge clock);
    setup_data = 24'h0C3C05;
    setup_imp  = 1'b1;
    @(negedge clock);
    chk("load_min_bad", {8'd0, data_ch}, 32'h0C0005);
    setup_imp = 1'b0;

    // Freeze for 20 cycles with a 10-cycle level load in the middle.
    rezhim    = 2'd3;
    saved_cnt = pulse_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i == 4) begin
        setup_data = 24'h010203;
        setup_imp  = 1'b1;
      end
      if (i == 5) begin
        chk("frozen_load", {8'd0, data_ch}, 32'h010203);
        setup_data = 24'h050505;
      end
      if (i == 14) begin
        chk("level_no_reload", {8'd0, data_ch}, 32'h010203);
        setup_imp = 1'b0;
      end
    end
    chk("freeze_no_pulse", pulse_cnt, saved_cnt);
    rezhim = 2'd0;
    push_exp(24'h010204, 1'b0);
    wait_pulse(10, cyc);
    chk("unfreeze_lat", cyc, 32'd5);

    // Collision: tick is high during the cycle containing the 3rd negedge after a pulse.
    repeat (3) @(negedge clock);
    setup_data = 24'h020304;
    setup_imp  = 1'b1;
    @(negedge clock);
    chk("collide_data", {8'd0, data_ch}, 32'h020304);
    chk("collide_no_pulse", {31'd0, sec_pulse}, 32'd0);
    setup_imp = 1'b0;
    push_exp(24'h020305, 1'b0);
    wait_pulse(10, cyc);
    chk("collide_next_lat", cyc, 32'd5);

    // Async reset mid-second, then prescaler restarts from 0.
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("async_rst_data", {8'd0, data_ch}, 32'd0);
    chk("async_rst_pulse", {30'd0, sec_pulse, day_wrap}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    push_exp(24'h000001, 1'b0);
    wait_pulse(10, cyc);
    chk("rst_restart_lat", cyc, 32'd5);

    // setup_imp held high across reset release loads exactly once.
    setup_data = 24'h030000;
    setup_imp  = 1'b1;
    reset      = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("release_load", {8'd0, data_ch}, 32'h030000);
    push_exp(24'h030001, 1'b0);
    wait_pulse(10, cyc);
    chk("release_load_lat", cyc, 32'd5);
    setup_imp = 1'b0;

    @(negedge clock);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
